// File: rtl/float12_pkg.sv
// float12_pkg: shared fp12 widths, constants and divider/multiplier control states
package float12_pkg;
  localparam int FP_W = 12;
  localparam int EXP_W = 5;
  localparam int MAN_W = 6;
  localparam int EXP_BIAS = 15;
  localparam logic [FP_W-1:0] FP_ZERO = 12'h000;
  localparam logic [FP_W-2:0] FP_SAT_MAG = 11'h7FF;
  typedef enum logic [2:0] {IDLE, LOAD, DIV, NORM, DONE} state_t;
endpackage

// File: rtl/mant_div_8.sv
// mant_div_8: 8-step restoring divide of (ma << 7) by mb, one quotient bit per cycle MSB first
module mant_div_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] ma,
  input  logic [6:0] mb,
  output logic       done,
  output logic [7:0] q
);
  logic       busy;
  logic [2:0] cnt;
  logic [7:0] r;
  logic       ge;
  logic [6:0] r_sub;
  // remainder stays below 2*mb, so 8 bits hold it and the trial difference fits in 7
  assign ge = r >= {1'b0, mb};
  assign r_sub = ge ? 7'(r - {1'b0, mb}) : r[6:0];
  assign done = busy && cnt == 3'd7;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      r <= '0;
      q <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      r <= {1'b0, ma};
      q <= '0;
    end else if (busy) begin
      r <= {r_sub, 1'b0};
      q <= {q[6:0], ge};
      cnt <= cnt + 3'd1;
      busy <= cnt != 3'd7;
    end
  end
endmodule

// File: rtl/float_div_12.sv
// float_div_12: fixed-latency fp12 divider; start at cycle 0 yields done_o at cycle 11
module float_div_12 import float12_pkg::*; (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [FP_W-1:0] data_1_i,
  input  logic [FP_W-1:0] data_2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [FP_W-1:0] data_div_o,
  output logic            div_by_zero_o
);
  state_t state, state_nxt;
  logic [FP_W-1:0] a, b;
  logic sign;
  logic signed [6:0] e_raw, exp_n;
  logic [MAN_W-1:0] man_n;
  logic [FP_W-1:0] res;
  logic dbz, div_done;
  logic [7:0] q;
  mant_div_8 u_mant_div (
    .clk   (clk_i),
    .rst   (rst_i),
    .start (state == LOAD),
    .ma    ({1'b1, a[MAN_W-1:0]}),
    .mb    ({1'b1, b[MAN_W-1:0]}),
    .done  (div_done),
    .q     (q)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      a <= FP_ZERO;
      b <= FP_ZERO;
      sign <= 1'b0;
      e_raw <= '0;
      data_div_o <= FP_ZERO;
      div_by_zero_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_i) begin
        a <= data_1_i;
        b <= data_2_i;
      end
      if (state == LOAD) begin
        sign <= a[FP_W-1] ^ b[FP_W-1];
        e_raw <= {2'b00, a[FP_W-2:MAN_W]} - {2'b00, b[FP_W-2:MAN_W]} + 7'(EXP_BIAS);
      end
      if (state == NORM) begin
        data_div_o <= res;
        div_by_zero_o <= dbz;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start_i ? LOAD : IDLE;
      LOAD: state_nxt = DIV;
      DIV:  state_nxt = div_done ? NORM : DIV;
      NORM: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // quotient lies in [64,254]; bit 7 decides whether the exponent needs a decrement
  always_comb begin
    exp_n = q[7] ? e_raw : e_raw - 7'sd1;
    man_n = q[7] ? q[6:1] : q[5:0];
    dbz = b == FP_ZERO;
    res = dbz ? {sign, FP_SAT_MAG} :
          a == FP_ZERO ? FP_ZERO :
          exp_n[6] ? FP_ZERO :
          exp_n > 7'sd31 ? {sign, FP_SAT_MAG} :
          {sign, exp_n[EXP_W-1:0], man_n};
  end
  assign busy_o = state == LOAD || state == DIV || state == NORM;
  assign done_o = state == DONE;
endmodule

// File: tb/tb_float_div_12.sv
// tb_float_div_12: directed checks of fp12 division results, latency, throughput and reset
module tb_float_div_12;
  logic clk = 1'b0, rst, start;
  logic [11:0] d1, d2, q;
  logic busy, done, dbz;
  int checks = 0, failures = 0;

  float_div_12 dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .data_1_i(d1), .data_2_i(d2),
    .busy_o(busy), .done_o(done), .data_div_o(q), .div_by_zero_o(dbz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; d1 = '0; d2 = '0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (q !== 12'h000) begin failures++; $display("FAIL reset_data got=%h exp=000", q); end
    checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
    rst = 1'b0;
    tick();
  endtask

  task automatic run_div(input logic [11:0] x, input logic [11:0] y, input logic [11:0] eq, input logic edz, input string nm);
    int n;
    start = 1'b1; d1 = x; d2 = y;
    tick();
    start = 1'b0;
    n = 1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_rise got=%b exp=1", nm, busy); end
    while (!done && n < 30) begin tick(); n++; end
    checks++; if (n != 11) begin failures++; $display("FAIL %s latency got=%0d exp=11", nm, n); end
    checks++; if (q !== eq) begin failures++; $display("FAIL %s data got=%h exp=%h", nm, q, eq); end
    checks++; if (dbz !== edz) begin failures++; $display("FAIL %s dbz got=%b exp=%b", nm, dbz, edz); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_in_done got=%b exp=0", nm, busy); end
    tick();
    checks++; if (done !== 1'b0 || q !== eq) begin failures++; $display("FAIL %s hold got=%b/%h exp=0/%h", nm, done, q, eq); end
  endtask

  task automatic test_basic();
    run_div(12'h420, 12'h400, 12'h3E0, 1'b0, "3div2");
    run_div(12'h3C0, 12'h420, 12'h355, 1'b0, "1div3");
    run_div(12'hC00, 12'h400, 12'hBC0, 1'b0, "neg");
  endtask

  task automatic test_special();
    run_div(12'h3C0, 12'h000, 12'h7FF, 1'b1, "div_zero");
    run_div(12'h000, 12'h3C0, 12'h000, 1'b0, "zero_dividend");
    run_div(12'h7FF, 12'h001, 12'h7FF, 1'b0, "overflow");
    run_div(12'h001, 12'h7FF, 12'h000, 1'b0, "underflow");
  endtask

  task automatic test_back_to_back();
    int dn = 0, viol = 0, c1 = 0, c2 = 0;
    logic [11:0] r1 = '0, r2 = '0;
    start = 1'b1; d1 = 12'h420; d2 = 12'h400;
    tick();
    d1 = 12'h3C0; d2 = 12'h420;
    for (int c = 1; c <= 35; c++) begin
      if (busy && done) viol++;
      if (done) begin
        dn++;
        if (dn == 1) begin c1 = c; r1 = q; end
        if (dn == 2) begin c2 = c; r2 = q; end
      end
      if (c == 35) start = 1'b0;
      tick();
    end
    checks++; if (dn != 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", dn); end
    checks++; if (c1 != 11) begin failures++; $display("FAIL b2b_first_cycle got=%0d exp=11", c1); end
    checks++; if (c2 != 23) begin failures++; $display("FAIL b2b_second_cycle got=%0d exp=23", c2); end
    checks++; if (r1 !== 12'h3E0) begin failures++; $display("FAIL b2b_first_data got=%h exp=3E0", r1); end
    checks++; if (r2 !== 12'h355) begin failures++; $display("FAIL b2b_second_data got=%h exp=355", r2); end
    checks++; if (viol != 0) begin failures++; $display("FAIL b2b_busy_in_done got=%0d exp=0", viol); end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    start = 1'b1; d1 = 12'h420; d2 = 12'h400;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) begin if (done) dn++; tick(); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got=%b%b exp=00", busy, done); end
    checks++; if (q !== 12'h000 || dbz !== 1'b0) begin failures++; $display("FAIL midrst_data got=%h/%b exp=000/0", q, dbz); end
    checks++; if (dn != 0) begin failures++; $display("FAIL midrst_early_done got=%0d exp=0", dn); end
    run_div(12'h3C0, 12'h420, 12'h355, 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
